// File: rtl/dmx_issue_arbiter.sv
// dmx_issue_arbiter: round-robin sharing of one dmx_hub CPU port among NUM_REQ requesters,
// with tid allocation, response routing and an atomic FP64 sequence lock.
// Optional stale-lock watchdog enabled by defining DMX_ARB_TIMEOUT_EN.

module dmx_arb_lane (
  input  logic       valid,
  input  logic [4:0] opcode,
  input  logic       tid_avail,
  input  logic       lock_active,
  input  logic       is_owner,
  output logic       is_load,
  output logic       eligible
);
  // FP64_LOAD_A_ROW0/1 and B_ROW0/1 occupy opcodes 0x10..0x13
  assign is_load  = (opcode[4:2] == 3'b100);
  assign eligible = valid && (is_load || tid_avail) && (!lock_active || is_owner);
endmodule

module dmx_issue_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 256,
  localparam int IW          = $clog2(NUM_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [5*NUM_REQ-1:0]    req_opcode,
  input  logic [2*NUM_REQ-1:0]    req_fmt,
  input  logic [64*NUM_REQ-1:0]   req_src0,
  input  logic [64*NUM_REQ-1:0]   req_src1,
  input  logic [64*NUM_REQ-1:0]   req_src2,
  output logic                    instr_valid,
  output logic [4:0]              instr_opcode,
  output logic [1:0]              instr_fmt,
  output logic [63:0]             instr_src0,
  output logic [63:0]             instr_src1,
  output logic [63:0]             instr_src2,
  output logic [3:0]              cpu_tid,
  input  logic                    cpu_req_ready,
  input  logic                    cpu_resp_valid,
  input  logic [3:0]              cpu_resp_tid,
  input  logic [63:0]             cpu_resp_data,
  input  logic [4:0]              cpu_resp_flags,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [63:0]             resp_data,
  output logic [4:0]              resp_flags,
  output logic                    lock_active,
  output logic [IW-1:0]           lock_owner,
  output logic [4:0]              outstanding_cnt,
  output logic                    err_unknown_tid,
  output logic                    err_lock_timeout
);
  localparam logic [4:0] OP_EXECUTE = 5'h14;

  typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          grant_q, grant_d, rr_q, rr_d, owner_q, owner_d;
  logic [3:0]             tid_q, tid_d;
  logic                   load_q, load_d, lock_q, lock_d, err_tid_q, err_tid_d;
  logic [15:0]            busy_q, busy_d;
  logic [15:0][IW-1:0]    own_q, own_d;

  logic [NUM_REQ-1:0]     is_load, elig;
  logic [3:0]             free_tid;
  logic                   tid_avail, fire;

  always_comb begin
    free_tid  = 4'd0;
    tid_avail = 1'b0;
    for (int t = 15; t >= 1; t--) begin
      if (!busy_q[t]) begin
        free_tid  = 4'(t);
        tid_avail = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    dmx_arb_lane u_lane (
      .valid       (req_valid[i]),
      .opcode      (req_opcode[i*5 +: 5]),
      .tid_avail   (tid_avail),
      .lock_active (lock_q),
      .is_owner    (owner_q == IW'(i)),
      .is_load     (is_load[i]),
      .eligible    (elig[i])
    );
  end

  // Issue fields follow the frozen grant; zero whenever nothing is offered.
  always_comb begin
    int g;
    g            = int'(grant_q);
    instr_valid  = (state_q == ST_ISSUE);
    instr_opcode = instr_valid ? req_opcode[g*5 +: 5]  : 5'd0;
    instr_fmt    = instr_valid ? req_fmt[g*2 +: 2]     : 2'd0;
    instr_src0   = instr_valid ? req_src0[g*64 +: 64]  : 64'd0;
    instr_src1   = instr_valid ? req_src1[g*64 +: 64]  : 64'd0;
    instr_src2   = instr_valid ? req_src2[g*64 +: 64]  : 64'd0;
    cpu_tid      = instr_valid ? tid_q : 4'd0;
  end

  assign fire       = (state_q == ST_ISSUE) && cpu_req_ready;
  assign resp_data  = cpu_resp_data;
  assign resp_flags = cpu_resp_flags;

  always_comb begin
    outstanding_cnt = 5'd0;
    for (int t = 1; t < 16; t++) outstanding_cnt += 5'(busy_q[t]);
  end

`ifdef DMX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_to_q, err_to_d;
  assign err_lock_timeout = err_to_q;
`else
  assign err_lock_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    tid_d     = tid_q;
    load_d    = load_q;
    lock_d    = lock_q;
    err_tid_d = err_tid_q;
    busy_d    = busy_q;
    own_d     = own_q;
    req_ready = '0;
    resp_valid = '0;

    if (cpu_resp_valid) begin
      if (cpu_resp_tid != 4'd0 && busy_q[cpu_resp_tid]) begin
        resp_valid[own_q[cpu_resp_tid]] = 1'b1;
        busy_d[cpu_resp_tid]            = 1'b0;
      end else begin
        err_tid_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        logic found;
        int   idx, pick;
        found = 1'b0;
        pick  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = int'(rr_q) + k;
          if (idx >= NUM_REQ) idx -= NUM_REQ;
          if (!found && elig[idx]) begin
            found = 1'b1;
            pick  = idx;
          end
        end
        if (found) begin
          grant_d = IW'(pick);
          load_d  = is_load[pick];
          tid_d   = is_load[pick] ? 4'd0 : free_tid;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cpu_req_ready) begin
          req_ready[grant_q] = 1'b1;
          if (!load_q) begin
            busy_d[tid_q] = 1'b1;
            own_d[tid_q]  = grant_q;
          end
          rr_d = (grant_q == IW'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
          if (load_q) begin
            lock_d  = 1'b1;
            owner_d = grant_q;
          end else if (instr_opcode == OP_EXECUTE) begin
            lock_d = 1'b0;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef DMX_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_to_d = err_to_q;
    if (!lock_q || (fire && grant_q == owner_q)) begin
      cnt_d = '0;
    end else if (!req_valid[owner_q]) begin
      if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
        lock_d   = 1'b0;
        err_to_d = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      owner_q   <= '0;
      tid_q     <= '0;
      load_q    <= 1'b0;
      lock_q    <= 1'b0;
      err_tid_q <= 1'b0;
      busy_q    <= '0;
      own_q     <= '0;
`ifdef DMX_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_to_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      tid_q     <= tid_d;
      load_q    <= load_d;
      lock_q    <= lock_d;
      err_tid_q <= err_tid_d;
      busy_q    <= busy_d;
      own_q     <= own_d;
`ifdef DMX_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_to_q  <= err_to_d;
`endif
    end
  end

  assign lock_active     = lock_q;
  assign lock_owner      = owner_q;
  assign err_unknown_tid = err_tid_q;

endmodule

// File: tb/tb_dmx_issue_arbiter.sv
// Directed bench for dmx_issue_arbiter: per-cycle vector table for basic issue/round-robin,
// hand-written sequences for lock, full-table, error and watchdog corners.
module tb_dmx_issue_arbiter;
  localparam int N = 4;
  localparam logic [4:0] OP_ADD = 5'h01, OP_MUL = 5'h02, OP_FMA = 5'h03;
  localparam logic [4:0] OP_LA0 = 5'h10, OP_LA1 = 5'h11, OP_LB0 = 5'h12, OP_LB1 = 5'h13;
  localparam logic [4:0] OP_EXE = 5'h14;
  localparam logic [63:0] RDATA = 64'h4010_0000;

  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0]      req_valid, req_ready, resp_valid;
  logic [5*N-1:0]    req_opcode;
  logic [2*N-1:0]    req_fmt;
  logic [64*N-1:0]   req_src0, req_src1, req_src2;
  logic              instr_valid, cpu_req_ready, cpu_resp_valid;
  logic [4:0]        instr_opcode, cpu_resp_flags, resp_flags, outstanding_cnt;
  logic [1:0]        instr_fmt, lock_owner;
  logic [63:0]       instr_src0, instr_src1, instr_src2, cpu_resp_data, resp_data;
  logic [3:0]        cpu_tid, cpu_resp_tid;
  logic              lock_active, err_unknown_tid, err_lock_timeout;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  dmx_issue_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(8)) dut (
    .clock(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode), .req_fmt(req_fmt),
    .req_src0(req_src0), .req_src1(req_src1), .req_src2(req_src2),
    .instr_valid(instr_valid), .instr_opcode(instr_opcode), .instr_fmt(instr_fmt),
    .instr_src0(instr_src0), .instr_src1(instr_src1), .instr_src2(instr_src2),
    .cpu_tid(cpu_tid), .cpu_req_ready(cpu_req_ready),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_tid(cpu_resp_tid),
    .cpu_resp_data(cpu_resp_data), .cpu_resp_flags(cpu_resp_flags),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_flags(resp_flags),
    .lock_active(lock_active), .lock_owner(lock_owner), .outstanding_cnt(outstanding_cnt),
    .err_unknown_tid(err_unknown_tid), .err_lock_timeout(err_lock_timeout)
  );

  typedef struct {
    logic [3:0] rv;   logic [4:0] op;  logic rdy; logic rsp; logic [3:0] rtid;
    logic e_iv; logic [3:0] e_tid; int e_gnt; logic [3:0] e_rr; logic [3:0] e_resp; logic [4:0] e_out;
  } vec_t;
  vec_t vt [0:15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [4:0] op);
    req_opcode[i*5 +: 5] = op;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; cpu_req_ready = 1'b1; cpu_resp_valid = 1'b0; cpu_resp_tid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits for a fire, returns requester index and tid; leaves control at posedge+1 after the fire.
  task automatic wait_fire(input int budget, output int who, output logic [3:0] tid);
    who = -1; tid = '0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) who = i;
        tid = cpu_tid;
        @(posedge clk); #1;
        break;
      end
    end
  endtask

  task automatic run_vec(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      @(negedge clk);
      req_valid = vt[r].rv;
      for (int i = 0; i < N; i++) set_op(i, vt[r].op);
      cpu_req_ready = vt[r].rdy; cpu_resp_valid = vt[r].rsp; cpu_resp_tid = vt[r].rtid;
      #1;
      chk($sformatf("v%0d instr_valid", r), 64'(instr_valid), 64'(vt[r].e_iv));
      chk($sformatf("v%0d cpu_tid", r), 64'(cpu_tid), 64'(vt[r].e_tid));
      chk($sformatf("v%0d req_ready", r), 64'(req_ready), 64'(vt[r].e_rr));
      chk($sformatf("v%0d src0", r), instr_src0, vt[r].e_iv ? 64'h1000 + 64'(vt[r].e_gnt) : 64'd0);
      chk($sformatf("v%0d opcode", r), 64'(instr_opcode), vt[r].e_iv ? 64'(vt[r].op) : 64'd0);
      chk($sformatf("v%0d resp_valid", r), 64'(resp_valid), 64'(vt[r].e_resp));
      chk($sformatf("v%0d outstanding", r), 64'(outstanding_cnt), 64'(vt[r].e_out));
      if (vt[r].e_resp != '0) chk($sformatf("v%0d resp_data", r), resp_data, RDATA);
    end
  endtask

  initial begin
    int who;
    logic [3:0] tid;
    logic ok;

    //           rv       op      rdy   rsp   rtid  iv    tid   g  rr       resp     out
    vt[0]  = '{4'b0001, OP_FMA, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 0, 4'b0000, 4'b0000, 5'd0};
    vt[1]  = '{4'b0001, OP_FMA, 1'b1, 1'b0, 4'd0, 1'b1, 4'd1, 0, 4'b0001, 4'b0000, 5'd0};
    vt[2]  = '{4'b0000, OP_FMA, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 0, 4'b0000, 4'b0000, 5'd1};
    vt[3]  = '{4'b0000, OP_FMA, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0, 0, 4'b0000, 4'b0001, 5'd1};
    vt[4]  = '{4'b0000, OP_FMA, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 0, 4'b0000, 4'b0000, 5'd0};
    vt[5]  = '{4'b1111, OP_ADD, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 0, 4'b0000, 4'b0000, 5'd0};
    vt[6]  = '{4'b1111, OP_ADD, 1'b1, 1'b0, 4'd0, 1'b1, 4'd1, 0, 4'b0001, 4'b0000, 5'd0};
    vt[7]  = '{4'b1111, OP_ADD, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 0, 4'b0000, 4'b0000, 5'd1};
    vt[8]  = '{4'b1111, OP_ADD, 1'b1, 1'b0, 4'd0, 1'b1, 4'd2, 1, 4'b0010, 4'b0000, 5'd1};
    vt[9]  = '{4'b1111, OP_ADD, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 0, 4'b0000, 4'b0000, 5'd2};
    vt[10] = '{4'b1111, OP_ADD, 1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 2, 4'b0100, 4'b0000, 5'd2};
    vt[11] = '{4'b1111, OP_ADD, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 0, 4'b0000, 4'b0000, 5'd3};
    vt[12] = '{4'b1111, OP_ADD, 1'b1, 1'b0, 4'd0, 1'b1, 4'd4, 3, 4'b1000, 4'b0000, 5'd3};
    vt[13] = '{4'b1111, OP_ADD, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 0, 4'b0000, 4'b0000, 5'd4};
    vt[14] = '{4'b1111, OP_ADD, 1'b1, 1'b0, 4'd0, 1'b1, 4'd5, 0, 4'b0001, 4'b0000, 5'd4};
    vt[15] = '{4'b1111, OP_ADD, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 0, 4'b0000, 4'b0000, 5'd5};

    req_opcode = '0; req_fmt = '0; req_src1 = '0; req_src2 = '0;
    for (int i = 0; i < N; i++) req_src0[i*64 +: 64] = 64'h1000 + 64'(i);
    cpu_resp_data = RDATA; cpu_resp_flags = 5'h05;

    // reset state
    do_reset();
    #1;
    chk("rst instr_valid", 64'(instr_valid), 64'd0);
    chk("rst cpu_tid", 64'(cpu_tid), 64'd0);
    chk("rst src0", instr_src0, 64'd0);
    chk("rst req_ready", 64'(req_ready), 64'd0);
    chk("rst lock", 64'({lock_active, lock_owner}), 64'd0);
    chk("rst outstanding", 64'(outstanding_cnt), 64'd0);
    chk("rst errs", 64'({err_unknown_tid, err_lock_timeout}), 64'd0);

    // single issue + response, then round-robin over four requesters
    run_vec(0, 4);
    chk("resp_flags", 64'(resp_flags), 64'h05);
    do_reset();
    run_vec(5, 15);

    // FP64 lock: req1 sequence runs atomically while req2 waits
    do_reset();
    req_valid = 4'b0110; set_op(1, OP_LA0); set_op(2, OP_ADD);
    wait_fire(10, who, tid);
    chk("lock la0 who", 64'(who), 64'd1);
    chk("lock la0 tid", 64'(tid), 64'd0);
    chk("lock held", 64'({lock_active, lock_owner}), 64'({1'b1, 2'd1}));
    set_op(1, OP_LA1); wait_fire(10, who, tid); chk("lock la1 who", 64'(who), 64'd1);
    set_op(1, OP_LB0); wait_fire(10, who, tid); chk("lock lb0 who", 64'(who), 64'd1);
    set_op(1, OP_LB1); wait_fire(10, who, tid); chk("lock lb1 who", 64'(who), 64'd1);
    set_op(1, OP_EXE); wait_fire(10, who, tid);
    chk("lock exe who", 64'(who), 64'd1);
    chk("lock exe tid", 64'(tid), 64'd1);
    chk("lock released", 64'(lock_active), 64'd0);
    req_valid = 4'b0100;
    wait_fire(10, who, tid);
    chk("post-lock who", 64'(who), 64'd2);
    chk("post-lock tid", 64'(tid), 64'd2);

    // fill the tid table, stall, free tid 7, LOAD still eligible when full
    do_reset();
    req_valid = 4'b0001; set_op(0, OP_ADD);
    for (int t = 1; t <= 15; t++) begin
      wait_fire(10, who, tid);
      chk($sformatf("fill%0d who", t), 64'(who), 64'd0);
      chk($sformatf("fill%0d tid", t), 64'(tid), 64'(t));
    end
    chk("full outstanding", 64'(outstanding_cnt), 64'd15);
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
      if (instr_valid || req_ready != '0) ok = 1'b0;
    end
    chk("full stalls", 64'(ok), 64'd1);
    @(negedge clk); cpu_resp_valid = 1'b1; cpu_resp_tid = 4'd7; #1;
    chk("free7 resp_valid", 64'(resp_valid), 64'b0001);
    @(posedge clk); #1; cpu_resp_valid = 1'b0;
    chk("free7 outstanding", 64'(outstanding_cnt), 64'd14);
    wait_fire(10, who, tid);
    chk("realloc tid", 64'(tid), 64'd7);
    chk("refull outstanding", 64'(outstanding_cnt), 64'd15);
    req_valid = 4'b0010; set_op(1, OP_LA0);
    wait_fire(10, who, tid);
    chk("full load who", 64'(who), 64'd1);
    chk("full load tid", 64'(tid), 64'd0);

    // reset discards the table: stale/free/zero tids flag an error, backpressure holds fields
    do_reset();
    #1;
    chk("post-rst outstanding", 64'(outstanding_cnt), 64'd0);
    @(negedge clk); cpu_resp_valid = 1'b1; cpu_resp_tid = 4'd3; #1;
    chk("stale resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    chk("stale err", 64'(err_unknown_tid), 64'd1);
    @(negedge clk); cpu_resp_tid = 4'd9; #1;
    chk("free9 resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk); cpu_resp_tid = 4'd0; #1;
    chk("tid0 resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk); cpu_resp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("err sticky", 64'(err_unknown_tid), 64'd1);
    @(negedge clk);
    cpu_req_ready = 1'b0; req_valid = 4'b0100; set_op(2, OP_MUL);
    req_fmt[4 +: 2] = 2'b01; req_src1[128 +: 64] = 64'hDEAD_BEEF_0000_0001;
    req_src2[128 +: 64] = 64'h0123_4567_89AB_CDEF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk($sformatf("hold%0d iv", c), 64'(instr_valid), 64'd1);
      chk($sformatf("hold%0d fields", c), {instr_opcode, instr_fmt, cpu_tid, req_ready, 49'd0},
          {OP_MUL, 2'b01, 4'd1, 4'b0000, 49'd0});
      chk($sformatf("hold%0d src", c), instr_src1 ^ instr_src2,
          64'hDEAD_BEEF_0000_0001 ^ 64'h0123_4567_89AB_CDEF);
    end
    @(negedge clk); cpu_req_ready = 1'b1; #1;
    chk("hold release ready", 64'(req_ready), 64'b0100);
    @(posedge clk); #1; req_valid = '0;
    chk("hold outstanding", 64'(outstanding_cnt), 64'd1);

    // stale lock: owner goes idle, req3 waits
    do_reset();
    req_valid = 4'b0001; set_op(0, OP_LA0); set_op(3, OP_ADD);
    wait_fire(10, who, tid);
    chk("to load who", 64'(who), 64'd0);
    req_valid = 4'b1000;
    repeat (7) @(posedge clk);
    #1;
    chk("to lock before", 64'(lock_active), 64'd1);
    @(posedge clk); #1;
`ifdef DMX_ARB_TIMEOUT_EN
    chk("to lock broken", 64'(lock_active), 64'd0);
    chk("to err", 64'(err_lock_timeout), 64'd1);
    wait_fire(10, who, tid);
    chk("to req3 granted", 64'(who), 64'd3);
`else
    chk("nto lock held", 64'(lock_active), 64'd1);
    chk("nto err", 64'(err_lock_timeout), 64'd0);
    ok = 1'b1;
    repeat (30) begin
      @(negedge clk); #1;
      if (req_ready != '0) ok = 1'b0;
    end
    chk("nto req3 blocked", 64'(ok), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
